// File: rtl/wb_sram_burst.sv
// wb_sram_burst
// Wishbone B4 single-port SRAM slave with classic and registered-feedback burst cycles.
// Supports a configurable data width with byte-lane writes and configurable first-beat
// wait states. Incrementing and wrapping bursts run at one beat per cycle. Addresses at
// or above MEM_WORDS get an error response.
//
// Ports:
//   clk_i  - clock, all logic on the rising edge
//   rst_i  - synchronous active-high reset
//   cyc_i  - bus cycle
//   stb_i  - strobe
//   adr_i  - word address (only used on the first beat of a cycle)
//   dat_i  - write data
//   sel_i  - byte-lane write enables (ignored on reads)
//   we_i   - write enable
//   cti_i  - cycle type: 010 incrementing burst, 111 end of burst, anything else classic
//   bte_i  - burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16
//   ack_o  - registered transfer acknowledge
//   err_o  - registered error (out-of-range address), high for one cycle
//   rty_o  - always 0
//   dat_o  - read data, valid while ack_o is high on reads
module wb_sram_burst #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_WORDS   = 2 ** ADDR_WIDTH,
    parameter int WAIT_STATES = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cyc_i,
    input  logic                    stb_i,
    input  logic [ADDR_WIDTH-1:0]   adr_i,
    input  logic [DATA_WIDTH-1:0]   dat_i,
    input  logic [DATA_WIDTH/8-1:0] sel_i,
    input  logic                    we_i,
    input  logic [2:0]              cti_i,
    input  logic [1:0]              bte_i,
    output logic                    ack_o,
    output logic                    err_o,
    output logic                    rty_o,
    output logic [DATA_WIDTH-1:0]   dat_o
);

    localparam int LANES = DATA_WIDTH / 8;
    // One bit wider than the address so MEM_WORDS = 2**ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK,
        ST_ERR
    } state_t;

    state_t                  state;
    logic [3:0]              wait_cnt;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   mem [MEM_WORDS];

    logic                    req;
    logic                    beat;
    logic [ADDR_WIDTH-1:0]   next_addr;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return {1'b0, a} < MEM_LIMIT;
    endfunction

    // Linear bursts increment the whole address; wrapping bursts only increment the
    // low 2/3/4 bits and keep the upper bits of the starting address.
    function automatic logic [ADDR_WIDTH-1:0] burst_next(input logic [ADDR_WIDTH-1:0] a,
                                                          input logic [1:0]            bte);
        logic [ADDR_WIDTH-1:0] inc;
        logic [ADDR_WIDTH-1:0] mask;
        inc = a + ADDR_WIDTH'(1);
        case (bte)
            2'b01:   mask = ADDR_WIDTH'(4'h3);
            2'b10:   mask = ADDR_WIDTH'(4'h7);
            2'b11:   mask = ADDR_WIDTH'(4'hF);
            default: mask = '1;
        endcase
        return (a & ~mask) | (inc & mask);
    endfunction

    assign req       = cyc_i & stb_i;
    assign beat      = req & ack_o;
    assign next_addr = burst_next(addr_q, bte_i);
    assign rty_o     = 1'b0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            ack_o    <= 1'b0;
            err_o    <= 1'b0;
            wait_cnt <= '0;
            addr_q   <= '0;
            // NOTE: dat_o is deliberately left out of reset; it is only meaningful while
            // ack_o is high, so resetting it would add reset fan-out for no benefit.
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        addr_q <= adr_i;
                        if (!in_range(adr_i)) begin
                            err_o <= 1'b1;
                            state <= ST_ERR;
                        end else if (WAIT_STATES == 0) begin
                            ack_o <= 1'b1;
                            state <= ST_ACK;
                            // The address register is loaded at this same edge, so read
                            // straight from adr_i to have data ready with the ack.
                            if (!we_i) dat_o <= mem[adr_i];
                        end else begin
                            wait_cnt <= 4'(WAIT_STATES - 1);
                            state    <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!req) begin
                        state <= ST_IDLE;
                    end else if (wait_cnt == '0) begin
                        ack_o <= 1'b1;
                        state <= ST_ACK;
                        if (!we_i) dat_o <= mem[addr_q];
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_ACK: begin
                    if (req && cti_i == 3'b010) begin
                        if (in_range(next_addr)) begin
                            // ack_o stays high: one beat per cycle, read data prefetched.
                            addr_q <= next_addr;
                            if (!we_i) dat_o <= mem[next_addr];
                        end else begin
                            ack_o <= 1'b0;
                            err_o <= 1'b1;
                            state <= ST_ERR;
                        end
                    end else begin
                        ack_o <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                ST_ERR: begin
                    err_o <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    ack_o <= 1'b0;
                    err_o <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // NOTE: the memory array has no reset branch; a reset loop over every word would
    // stop it mapping onto RAM. Reset only has to block the write at its edge.
    always_ff @(posedge clk_i) begin
        if (!rst_i && beat && we_i) begin
            for (int b = 0; b < LANES; b++) begin
                if (sel_i[b]) mem[addr_q][b*8 +: 8] <= dat_i[b*8 +: 8];
            end
        end
    end

endmodule
